// File: rtl/memoria_principal_responder.sv
// Main-memory responder: fixed-latency line-fill reads over a valid/ready pair,
// plus a one-entry posted write-back buffer with read-after-write forwarding.
module memoria_principal_responder #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LATENCY    = 3,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] WB_CNT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("memoria_principal_responder: LATENCY must be within 1..15");
  end

  if (INIT_FILE != "") begin : g_init_file
    $warning("memoria_principal_responder: INIT_FILE image not loaded; ramp image used");
  end

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_e;

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

  // Power-up image: the ramp mem[i] = i+1.
  function automatic mem_t mem_image();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = DATA_WIDTH'(i + 1);
    end
    return m;
  endfunction

  mem_t mem = mem_image();

  rd_state_e             rd_state_q, rd_state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  busy_q, busy_d;

  logic                  wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0]      wb_cnt_q, wb_cnt_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  mem_we;

  logic                  rd_accept;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;

  // A pending write only blocks another write; reads may overlap the drain.
  assign req_ready  = (rd_state_q == RD_IDLE) && !(wb_valid_q && req_write);
  assign rd_accept  = req_valid && req_ready && !req_write;
  assign wr_accept  = req_valid && req_ready && req_write;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = busy_q;

  // Capture source; LATENCY=1 samples straight off the request address.
  always_comb begin
    cap_addr = (rd_state_q == RD_IDLE) ? req_addr : rd_addr_q;
    cap_data = mem[cap_addr];
    if (wb_valid_q && (wb_addr_q == cap_addr)) begin
      cap_data = wb_data_q;
    end
  end

  // Read FSM next state and response register.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_addr_d    = rd_addr_q;
    resp_rdata_d = resp_rdata_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (rd_accept) begin
          rd_addr_d = req_addr;
          if (LATENCY == 1) begin
            resp_rdata_d = cap_data;
            rd_state_d   = RD_RESP;
          end else begin
            rd_cnt_d   = RD_CNT_INIT;
            rd_state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rd_cnt_d = rd_cnt_q - CNT_ONE;
        if (rd_cnt_q == CNT_ONE) begin
          resp_rdata_d = cap_data;
          rd_state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (resp_ready) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Posted write buffer: drains into the array LATENCY edges after acceptance.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_cnt_d   = wb_cnt_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    mem_we     = 1'b0;
    if (wb_valid_q) begin
      wb_cnt_d = wb_cnt_q - CNT_ONE;
      if (wb_cnt_q == CNT_ONE) begin
        mem_we     = 1'b1;
        wb_valid_d = 1'b0;
      end
    end
    if (wr_accept) begin
      wb_valid_d = 1'b1;
      wb_cnt_d   = WB_CNT_INIT;
      wb_addr_d  = req_addr;
      wb_data_d  = req_wdata;
    end
  end

  always_comb begin
    resp_valid_d = (rd_state_d == RD_RESP);
    busy_d       = (rd_state_d != RD_IDLE) || wb_valid_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state_q   <= RD_IDLE;
      rd_cnt_q     <= '0;
      rd_addr_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_cnt_q     <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_addr_q    <= rd_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
      wb_valid_q   <= wb_valid_d;
      wb_cnt_q     <= wb_cnt_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // Storage array is never reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wb_addr_q] <= wb_data_q;
    end
  end

endmodule

// File: tb/tb_memoria_principal_responder.sv
// Bench for memoria_principal_responder: directed timing sequences, a vector
// table and randomized traffic scored against a transaction-level memory model.
module tb_memoria_principal_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_ready;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_busy;
  logic [15:0] a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_busy;
  logic [15:0] b_resp_rdata;

  logic        o_req_ready, o_resp_valid, o_busy;
  logic [15:0] o_resp_rdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mdl [2][64];

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  always #5 clock = ~clock;

  assign a_req_valid  = req_valid && !sel;
  assign b_req_valid  = req_valid && sel;
  assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign o_busy       = sel ? b_busy       : a_busy;
  assign o_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;

  memoria_principal_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LATENCY(3)) u_dut_l3 (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
    .busy(a_busy)
  );

  memoria_principal_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LATENCY(1)) u_dut_l1 (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata),
    .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [5:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (o_req_ready) begin
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    timeout("issue");
  endtask

  task automatic get_resp(input logic [15:0] exp, input string nm);
    resp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (o_resp_valid) begin
        chk(nm, 32'(o_resp_rdata), 32'(exp));
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    resp_ready = 1'b0;
    timeout(nm);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [15:0] exp, input string nm);
    issue(1'b0, a, 16'h0);
    get_resp(exp, nm);
  endtask

  // Randomized traffic; the model tracks outstanding transactions by cycle number.
  task automatic rand_run(input logic s, input int lat, input int ncyc);
    int          cyc;
    int          rd_acc;
    int          wb_acc;
    bit          rd_p;
    bit          wb_p;
    bit          wb_live;
    bit          hold;
    bit          e_valid, e_busy, e_ready, acc, hs;
    logic [15:0] rd_dat;
    cyc    = 0;
    rd_acc = 0;
    wb_acc = 0;
    rd_p   = 1'b0;
    wb_p   = 1'b0;
    hold   = 1'b0;
    rd_dat = '0;
    sel    = s;
    for (int k = 0; k < ncyc; k++) begin
      if (!hold) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 6'($urandom);
        req_wdata = 16'($urandom);
        if (k >= ncyc - 20) req_valid = 1'b0;
      end
      resp_ready = (k >= ncyc - 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clock);
      wb_live = wb_p && (cyc < wb_acc + lat);
      e_valid = rd_p && (cyc >= rd_acc + lat - 1);
      e_busy  = rd_p || wb_live;
      e_ready = !rd_p && !(wb_live && req_write);
      chk("rand_req_ready", 32'(o_req_ready), 32'(e_ready));
      chk("rand_resp_valid", 32'(o_resp_valid), 32'(e_valid));
      chk("rand_busy", 32'(o_busy), 32'(e_busy));
      if (e_valid) chk("rand_resp_rdata", 32'(o_resp_rdata), 32'(rd_dat));
      acc = req_valid && e_ready;
      hs  = e_valid && resp_ready;
      @(posedge clock);
      cyc++;
      if (hs) rd_p = 1'b0;
      if (acc && !req_write) begin
        rd_p   = 1'b1;
        rd_acc = cyc;
        rd_dat = mdl[s][req_addr];
      end
      if (acc && req_write) begin
        mdl[s][req_addr] = req_wdata;
        wb_p   = 1'b1;
        wb_acc = cyc;
      end
      hold = req_valid && !acc;
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) mdl[s][i] = 16'(i + 1);

    tbl[0]  = '{1'b1, 6'd18, 16'd19,   16'd0};
    tbl[1]  = '{1'b0, 6'd18, 16'd0,    16'd19};
    tbl[2]  = '{1'b0, 6'd12, 16'd0,    16'd13};
    tbl[3]  = '{1'b0, 6'd0,  16'd0,    16'd1};
    tbl[4]  = '{1'b0, 6'd63, 16'd0,    16'd64};
    tbl[5]  = '{1'b1, 6'd63, 16'hFFFF, 16'd0};
    tbl[6]  = '{1'b0, 6'd63, 16'd0,    16'hFFFF};
    tbl[7]  = '{1'b1, 6'd40, 16'h1234, 16'd0};
    tbl[8]  = '{1'b1, 6'd41, 16'h5678, 16'd0};
    tbl[9]  = '{1'b0, 6'd40, 16'd0,    16'h1234};
    tbl[10] = '{1'b0, 6'd41, 16'd0,    16'h5678};
    tbl[11] = '{1'b0, 6'd39, 16'd0,    16'd40};

    reset      = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_resp_valid_l3", 32'(a_resp_valid), 0);
    chk("rst_resp_rdata_l3", 32'(a_resp_rdata), 0);
    chk("rst_busy_l3", 32'(a_busy), 0);
    chk("rst_req_ready_l3", 32'(a_req_ready), 1);
    chk("rst_resp_valid_l1", 32'(b_resp_valid), 0);
    chk("rst_busy_l1", 32'(b_busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Read latency: response seen at edge t+3, gone after handshake
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 6'd12;
    resp_ready = 1'b1;
    @(negedge clock);
    chk("t1_req_ready", 32'(o_req_ready), 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("t1_resp_valid_c%0d", i), 32'(o_resp_valid), (i == 2) ? 1 : 0);
      if (i == 2) chk("t1_resp_rdata", 32'(o_resp_rdata), 13);
      if (i == 0) chk("t1_busy", 32'(o_busy), 1);
      if (i == 3) chk("t1_busy_after", 32'(o_busy), 0);
      @(posedge clock);
      #1;
    end
    resp_ready = 1'b0;

    // Back-to-back writes: second stalls until t+4
    issue(1'b1, 6'd9, 16'd10);
    mdl[0][9] = 16'd10;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 6'd27;
    req_wdata = 16'd28;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk($sformatf("t3_req_ready_c%0d", i), 32'(o_req_ready), (i == 4) ? 1 : 0);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    mdl[0][27] = 16'd28;
    do_read(6'd9, 16'd10, "t3_rd9");
    do_read(6'd27, 16'd28, "t3_rd27");

    // Response backpressure: data held, no new request taken
    issue(1'b0, 6'd20, 16'h0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'd5;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clock);
        if (o_resp_valid) seen = 1'b1;
        else begin
          @(posedge clock);
          #1;
        end
      end
      if (!seen) timeout("t4_wait_valid");
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_resp_valid", 32'(o_resp_valid), 1);
      chk("t4_resp_rdata", 32'(o_resp_rdata), 21);
      chk("t4_req_ready", 32'(o_req_ready), 0);
      @(posedge clock);
      #1;
      @(negedge clock);
    end
    resp_ready = 1'b1;
    chk("t4_resp_valid_hs", 32'(o_resp_valid), 1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t4_resp_valid_after", 32'(o_resp_valid), 0);
    chk("t4_req_ready_after", 32'(o_req_ready), 1);
    @(posedge clock);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    get_resp(16'd6, "t4_rd5");

    // Reset while a write is still buffered: write is lost
    issue(1'b1, 6'd3, 16'd8);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_busy_in_reset", 32'(o_busy), 0);
    chk("t5_resp_valid_in_reset", 32'(o_resp_valid), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    do_read(6'd3, 16'd4, "t5_rd3");

    // Vector table on the LATENCY=3 instance
    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].wr) mdl[0][tbl[i].addr] = tbl[i].wdata;
      else get_resp(tbl[i].exp, $sformatf("vec%0d_rdata", i));
    end
    @(negedge clock);
    chk("tbl_busy_idle", 32'(o_busy), 0);
    @(posedge clock);
    #1;

    // LATENCY=1 instance
    sel        = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 6'd0;
    resp_ready = 1'b1;
    @(negedge clock);
    chk("t6_req_ready", 32'(o_req_ready), 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("t6_resp_valid", 32'(o_resp_valid), 1);
    chk("t6_resp_rdata", 32'(o_resp_rdata), 1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t6_resp_valid_after", 32'(o_resp_valid), 0);
    chk("t6_busy_after", 32'(o_busy), 0);
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    issue(1'b1, 6'd5, 16'hAAAA);
    mdl[1][5] = 16'hAAAA;
    do_read(6'd5, 16'hAAAA, "t6_rd5");

    rand_run(1'b1, 1, 800);
    rand_run(1'b0, 3, 800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
